bit_unstuff: RTL and testbench
==============================

# bit_unstuff

Receive-side bit unstuffer: the inverse of the transmit-side bit stuffer, which inserts a 0 after every run of six consecutive 1s. It counts consecutive 1s on a qualified serial bit stream and deletes the stuffed 0 that must follow each full run. If a 1 arrives where a stuffed 0 is required, it flags a stuffing violation. It sits between the line receiver/deserializer front end and the packet decoder.

## Interface
- MAX_ONES, 6, run length of consecutive 1s after which the next bit is a stuffed 0; legal range 2..15
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  qualifies inb this cycle; bits with in_valid=0 are ignored
- inb  input  1  received (stuffed) bit
- clear  input  1  synchronous soft clear; exits error state, zeroes run count
- out_valid  output  1  registered; outb carries a payload bit this cycle
- outb  output  1  registered unstuffed payload bit; 0 whenever out_valid=0
- drop  output  1  registered one-cycle pulse: a stuffed 0 was removed
- stuff_err  output  1  sticky: stuffing violation detected
- drop_cnt  output  16  stripped-bit count (only with BIT_UNSTUFF_STATS_EN)

## Operation
- Run counter cnt: width $clog2(MAX_ONES+1); reset value 0.
- The FSM has three states.
- RUN (reset state):
  - valid 1: forwarded; cnt+1; on reaching MAX_ONES, cnt clears to 0 and the FSM moves to STRIP.
  - valid 0: forwarded; cnt=0.
- STRIP:
  - valid 0: removed (out_valid=0, drop=1); cnt=0; FSM returns to RUN.
  - valid 1: not forwarded; stuff_err set; FSM moves to ERR.
- ERR:
  - All input is discarded; out_valid and drop stay 0.
  - The FSM stays here until clear or rst.
- The MAX_ONES-th 1 of a run is always forwarded; only the following 0 is removed.
- Cycles with in_valid=0 hold state and cnt unchanged in every state; gaps of any length inside a run do not break it.
- clear (any state):
  - FSM to RUN, cnt=0, stuff_err=0.
  - The bit presented in the same cycle is discarded.
  - clear has priority over in_valid.
- rst has priority over clear. It is legal mid-run or in STRIP; any partial run is forgotten.

## Timing
- Latency is one cycle. Input accepted at edge N produces out_valid/outb/drop at edge N+1.
- Throughput is one bit per cycle, with no backpressure. Downstream must accept every out_valid cycle.
- The cycle after any accepted bit carries exactly one of out_valid or drop. After a violation or discarded bit, it carries neither.
- stuff_err rises one cycle after the offending bit. It stays high until clear or rst, and falls the cycle after clear.
- Reset values: out_valid=0, outb=0, drop=0, stuff_err=0, drop_cnt=0, FSM=RUN, cnt=0.

## Configuration
- BIT_UNSTUFF_STATS_EN defined:
  - The drop_cnt port and a 16-bit counter exist.
  - The counter increments in the same cycle drop is registered, and saturates at 16'hFFFF.
  - rst and clear zero it.
- Not defined: drop_cnt port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: rst=1 for 2 cycles with random in_valid/inb -> out_valid=0, outb=0, drop=0, stuff_err=0 each cycle after reset.
- Basic strip: valid bits 1,1,1,1,1,1,0,1 -> out_valid bits 1,1,1,1,1,1,1 (seven bits); one drop pulse exactly one cycle after the 0 is input; stuff_err=0.
- No strip on short run: 1,1,1,1,1,0,1 -> all seven bits forwarded unchanged; drop never asserts.
- Gapped run: six 1s with 3 idle (in_valid=0) cycles between each, then 0 -> six 1s forwarded, 0 dropped.
- Violation and recovery:
  - Input 1×7 -> six 1s forwarded; stuff_err=1 one cycle after the 7th bit.
  - Further bits 0,1 produce nothing.
  - Pulse clear -> stuff_err=0; subsequent 0,1 forwarded.
- Stats (BIT_UNSTUFF_STATS_EN):
  - Three stuffed sequences (1×6,0) -> drop_cnt=3.
  - Pulse clear -> drop_cnt=0.
  - Preload 16'hFFFF by forcing, then one strip -> drop_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/bit_unstuff.sv
// bit_unstuff: receive-side bit unstuffer. It strips the stuffed 0 that follows
// each run of MAX_ONES consecutive 1s, and flags a 1 found in that position.
// Ports: clk, rst (sync, active-high), in_valid/inb (qualified serial input),
//        clear (soft clear), out_valid/outb (payload), drop (stripped-bit pulse),
//        stuff_err (sticky violation), drop_cnt (only with BIT_UNSTUFF_STATS_EN).
// Optional feature macro: BIT_UNSTUFF_STATS_EN adds the saturating drop_cnt.
module bit_unstuff #(
    parameter int MAX_ONES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        inb,
    input  logic        clear,
    output logic        out_valid,
    output logic        outb,
    output logic        drop,
    output logic        stuff_err
`ifdef BIT_UNSTUFF_STATS_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    localparam int CW = $clog2(MAX_ONES + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_ONES - 1);

    typedef enum logic [1:0] {
        RUN,
        STRIP,
        ERR
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          ov_nx, ob_nx, drop_nx, err_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ov_nx    = 1'b0;
        ob_nx    = 1'b0;
        drop_nx  = 1'b0;
        err_nx   = stuff_err;
        if (clear) begin
            // The bit presented alongside clear is discarded.
            state_nx = RUN;
            cnt_nx   = '0;
            err_nx   = 1'b0;
        end else if (in_valid) begin
            unique case (state)
                RUN: begin
                    ov_nx = 1'b1;
                    ob_nx = inb;
                    if (!inb) begin
                        cnt_nx = '0;
                    end else if (cnt == LAST) begin
                        // The run-completing 1 is still forwarded.
                        cnt_nx   = '0;
                        state_nx = STRIP;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                STRIP: begin
                    if (!inb) begin
                        drop_nx  = 1'b1;
                        cnt_nx   = '0;
                        state_nx = RUN;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = ERR;
                    end
                end
                ERR: begin
                end
                default: begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            out_valid <= 1'b0;
            outb      <= 1'b0;
            drop      <= 1'b0;
            stuff_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            out_valid <= ov_nx;
            outb      <= ob_nx;
            drop      <= drop_nx;
            stuff_err <= err_nx;
        end
    end

`ifdef BIT_UNSTUFF_STATS_EN
    logic [15:0] dcnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            dcnt <= '0;
        end else if (drop_nx && dcnt != 16'hFFFF) begin
            dcnt <= dcnt + 16'd1;
        end
    end

    assign drop_cnt = dcnt;
`endif

endmodule

// File: tb/tb_bit_unstuff.sv
// tb_bit_unstuff: table-driven bench for bit_unstuff (MAX_ONES=6), plus
// hand-written sequences for reset, gapped runs, reset mid-strip and stats.
module tb_bit_unstuff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        inb = 1'b0;
    logic        clear = 1'b0;
    logic        out_valid, outb, drop, stuff_err;
`ifdef BIT_UNSTUFF_STATS_EN
    logic [15:0] drop_cnt;
`endif

    int passed = 0;
    int total  = 0;

    bit_unstuff #(.MAX_ONES(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .inb       (inb),
        .clear     (clear),
        .out_valid (out_valid),
        .outb      (outb),
        .drop      (drop),
        .stuff_err (stuff_err)
`ifdef BIT_UNSTUFF_STATS_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v, b, c;
        logic ov, ob, dr, er;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic v, logic b, logic c,
                                logic ov, logic ob, logic dr, logic er);
        vec_t t;
        t.v = v; t.b = b; t.c = c;
        t.ov = ov; t.ob = ob; t.dr = dr; t.er = er;
        tbl.push_back(t);
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one cycle of input, then check the registered outputs.
    task automatic step(string tag, logic v, logic b, logic c,
                        logic ov, logic ob, logic dr, logic er);
        in_valid = v; inb = b; clear = c;
        @(posedge clk); #1;
        chk({tag, ".out_valid"}, 16'(out_valid), 16'(ov));
        chk({tag, ".outb"},      16'(outb),      16'(ob));
        chk({tag, ".drop"},      16'(drop),      16'(dr));
        chk({tag, ".stuff_err"}, 16'(stuff_err), 16'(er));
    endtask

    initial begin
        // Basic strip: 1x6, 0 (dropped), 1
        for (int i = 0; i < 6; i++) add(1, 1, 0, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        add(1, 1, 0, 1, 1, 0, 0);
        // Close that run, then short run of five: nothing dropped
        add(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 1, 0, 1, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        // Idle cycle
        add(0, 1, 0, 0, 0, 0, 0);
        // Violation: 1x7, then 0,1 discarded, clear (with a 1) discarded
        for (int i = 0; i < 6; i++) add(1, 1, 0, 1, 1, 0, 0);
        add(1, 1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 1, 0, 0);
        // Clear mid-run forgets the partial run: 1 + clear + 1x5 then 0 kept
        add(1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 1, 0, 1, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            rst = 1'b1;
            in_valid = 1'($urandom); inb = 1'($urandom); clear = 1'b0;
            @(posedge clk); #1;
            chk("rst.out_valid", 16'(out_valid), 16'd0);
            chk("rst.outb",      16'(outb),      16'd0);
            chk("rst.drop",      16'(drop),      16'd0);
            chk("rst.stuff_err", 16'(stuff_err), 16'd0);
        end
        rst = 1'b0;

        foreach (tbl[i]) begin
            step($sformatf("tbl%0d", i), tbl[i].v, tbl[i].b, tbl[i].c,
                 tbl[i].ov, tbl[i].ob, tbl[i].dr, tbl[i].er);
        end

        // Gapped run: six 1s with 3 idle cycles after each, then 0 dropped
        for (int i = 0; i < 6; i++) begin
            step("gap.one", 1, 1, 0, 1, 1, 0, 0);
            for (int j = 0; j < 3; j++) step("gap.idle", 0, 0, 0, 0, 0, 0, 0);
        end
        step("gap.zero", 1, 0, 0, 0, 0, 1, 0);
        step("gap.after", 1, 1, 0, 1, 1, 0, 0);
        step("gap.close", 1, 0, 0, 1, 0, 0, 0);

        // Reset while in STRIP: the following 0 is forwarded
        for (int i = 0; i < 6; i++) step("rs.one", 1, 1, 0, 1, 1, 0, 0);
        rst = 1'b1; in_valid = 1'b0; clear = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        step("rs.zero", 1, 0, 0, 1, 0, 0, 0);

`ifdef BIT_UNSTUFF_STATS_EN
        step("st.clr", 0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 6; i++) step("st.one", 1, 1, 0, 1, 1, 0, 0);
            step("st.zero", 1, 0, 0, 0, 0, 1, 0);
        end
        chk("drop_cnt3", drop_cnt, 16'd3);
        step("st.clr2", 0, 0, 1, 0, 0, 0, 0);
        chk("drop_cnt0", drop_cnt, 16'd0);
        force dut.dcnt = 16'hFFFF;
        @(posedge clk); #1;
        release dut.dcnt;
        for (int i = 0; i < 6; i++) step("sat.one", 1, 1, 0, 1, 1, 0, 0);
        step("sat.zero", 1, 0, 0, 0, 0, 1, 0);
        chk("drop_cnt_sat", drop_cnt, 16'hFFFF);
`endif

        in_valid = 1'b0; clear = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
